// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the scalar RV32 core: walks fetch/decode/execute/memory/writeback,
// owns the architectural PC and retire/cycle counters, and traps stalled stages via a watchdog.
module core_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
    output logic             fetch_en,
    input  logic             fetch_done,
    output logic             decode_en,
    input  logic             decode_done,
    input  logic             need_mem,
    input  logic             need_wb,
    output logic             exec_en,
    input  logic             exec_done,
    input  logic [31:0]      next_pc,
    output logic             mem_en,
    input  logic             mem_done,
    output logic             wb_en,
    input  logic             wb_done,
    output logic [31:0]      pc,
    output logic             running,
    output logic             error,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] cycles
);

    typedef enum logic [3:0] {
        StIdle, StFIss, StFWt, StDIss, StDWt, StEIss, StEWt,
        StMIss, StMWt, StWIss, StWWt, StErr
    } state_t;

    state_t      state_q, state_d, retire_to;
    logic [31:0] wdog_q;
    logic [31:0] npc_q;
    logic        need_mem_q, need_wb_q, halt_pend_q;
    logic        wt_done, is_wt, is_iss, timeout, retire_now;

    always_comb begin
        wt_done = 1'b0;
        is_wt   = 1'b1;
        unique case (state_q)
            StFWt:   wt_done = fetch_done;
            StDWt:   wt_done = decode_done;
            StEWt:   wt_done = exec_done;
            StMWt:   wt_done = mem_done;
            StWWt:   wt_done = wb_done;
            default: is_wt   = 1'b0;
        endcase
    end

    assign is_iss  = (state_q == StFIss) || (state_q == StDIss) || (state_q == StEIss) ||
                     (state_q == StMIss) || (state_q == StWIss);
    assign timeout = is_wt && !wt_done && (TIMEOUT != 0) && (wdog_q == TIMEOUT);
    assign retire_to = halt_pend_q ? StIdle : StFIss;

    always_comb begin
        state_d    = state_q;
        retire_now = 1'b0;
        unique case (state_q)
            StIdle: if (start) state_d = StFIss;
            StFIss: state_d = StFWt;
            StFWt:  if (fetch_done) state_d = StDIss;
            StDIss: state_d = StDWt;
            StDWt:  if (decode_done) state_d = StEIss;
            StEIss: state_d = StEWt;
            StEWt: begin
                if (exec_done) begin
                    if (need_mem_q) begin
                        state_d = StMIss;
                    end else if (need_wb_q) begin
                        state_d = StWIss;
                    end else begin
                        state_d    = retire_to;
                        retire_now = 1'b1;
                    end
                end
            end
            StMIss: state_d = StMWt;
            StMWt: begin
                if (mem_done) begin
                    if (need_wb_q) begin
                        state_d = StWIss;
                    end else begin
                        state_d    = retire_to;
                        retire_now = 1'b1;
                    end
                end
            end
            StWIss: state_d = StWWt;
            StWWt: begin
                if (wb_done) begin
                    state_d    = retire_to;
                    retire_now = 1'b1;
                end
            end
            StErr:   state_d = StErr;
            default: state_d = StIdle;
        endcase
        if (timeout) state_d = StErr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pc          <= RESET_PC;
            npc_q       <= 32'd0;
            need_mem_q  <= 1'b0;
            need_wb_q   <= 1'b0;
            halt_pend_q <= 1'b0;
            wdog_q      <= 32'd0;
            fetch_en    <= 1'b0;
            decode_en   <= 1'b0;
            exec_en     <= 1'b0;
            mem_en      <= 1'b0;
            wb_en       <= 1'b0;
            running     <= 1'b0;
            error       <= 1'b0;
            retire      <= 1'b0;
            instret     <= '0;
            cycles      <= '0;
        end else begin
            state_q   <= state_d;
            fetch_en  <= (state_d == StFIss);
            decode_en <= (state_d == StDIss);
            exec_en   <= (state_d == StEIss);
            mem_en    <= (state_d == StMIss);
            wb_en     <= (state_d == StWIss);
            running   <= (state_d != StIdle) && (state_d != StErr);
            error     <= (state_d == StErr);
            retire    <= retire_now;

            if (is_iss) begin
                wdog_q <= 32'd0;
            end else if (is_wt && !wt_done) begin
                wdog_q <= wdog_q + 32'd1;
            end

            if (state_q == StDWt && decode_done) begin
                need_mem_q <= need_mem;
                need_wb_q  <= need_wb;
            end
            if (state_q == StEWt && exec_done) npc_q <= next_pc;

            // A branch-like op retires in E_WT, before next_pc has reached npc_q.
            if (retire_now) begin
                pc      <= (state_q == StEWt) ? next_pc : npc_q;
                instret <= instret + CNT_W'(1);
            end

            if (state_d == StIdle) begin
                halt_pend_q <= 1'b0;
            end else if (running && halt_req) begin
                halt_pend_q <= 1'b1;
            end

            if (running) cycles <= cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: stage responders with per-stage delays, checked cycle by cycle.
module tb_core_sequencer;

    logic        clk, rst, start, halt_req;
    logic        fetch_en, fetch_done, decode_en, decode_done, need_mem, need_wb;
    logic        exec_en, exec_done, mem_en, mem_done, wb_en, wb_done;
    logic [31:0] next_pc, pc;
    logic        running, error, retire;
    logic [31:0] instret, cycles;
    logic [4:0]  en_vec;

    int checks   = 0;
    int failures = 0;

    // Stage responders, index 4..0 = fetch, decode, execute, memory, writeback.
    logic [4:0] dq;
    int         dly [5];
    int         cnt [5];

    core_sequencer #(
        .RESET_PC (32'h0000_0080),
        .TIMEOUT  (4),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .halt_req    (halt_req),
        .fetch_en    (fetch_en),
        .fetch_done  (fetch_done),
        .decode_en   (decode_en),
        .decode_done (decode_done),
        .need_mem    (need_mem),
        .need_wb     (need_wb),
        .exec_en     (exec_en),
        .exec_done   (exec_done),
        .next_pc     (next_pc),
        .mem_en      (mem_en),
        .mem_done    (mem_done),
        .wb_en       (wb_en),
        .wb_done     (wb_done),
        .pc          (pc),
        .running     (running),
        .error       (error),
        .retire      (retire),
        .instret     (instret),
        .cycles      (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign en_vec      = {fetch_en, decode_en, exec_en, mem_en, wb_en};
    assign fetch_done  = dq[4] & ~fetch_en;
    assign decode_done = dq[3] & ~decode_en;
    assign exec_done   = dq[2] & ~exec_en;
    assign mem_done    = dq[1] & ~mem_en;
    assign wb_done     = dq[0] & ~wb_en;

    // dly = number of WT cycles with done low before done rises.
    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (rst) begin
                dq[i]  <= 1'b0;
                cnt[i] <= 0;
            end else if (en_vec[i]) begin
                dq[i]  <= (dly[i] == 0);
                cnt[i] <= dly[i];
            end else if (!dq[i] && cnt[i] > 0) begin
                if (cnt[i] == 1) dq[i] <= 1'b1;
                cnt[i] <= cnt[i] - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        int       mem_cnt, mw_cnt, f_cnt, wb_c, ret_c;
        logic [31:0] cyc15, pc15;
        logic [4:0]  exp_en;

        rst = 1'b1; start = 1'b0; halt_req = 1'b0;
        need_mem = 1'b0; need_wb = 1'b0; next_pc = 32'd0;
        for (int i = 0; i < 5; i++) dly[i] = 0;
        tick(); tick();
        chk("rst_pc", pc, 32'h80);
        chk("rst_en", en_vec, 5'b0);
        chk("rst_flags", {running, error, retire}, 3'b000);
        chk("rst_instret", instret, 0);
        chk("rst_cycles", cycles, 0);
        rst = 1'b0;

        // ALU op: enables at 1,3,5,7; retire at 9.
        need_wb = 1'b1; next_pc = 32'd4;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            exp_en = (c == 1) ? 5'b10000 : (c == 3) ? 5'b01000 : (c == 5) ? 5'b00100 :
                     (c == 7) ? 5'b00001 : 5'b00000;
            chk($sformatf("t1_en_c%0d", c), en_vec, exp_en);
            chk($sformatf("t1_retire_c%0d", c), retire, (c == 9));
            if (c == 9) begin
                chk("t1_pc", pc, 32'd4);
                chk("t1_instret", instret, 1);
                chk("t1_cycles", cycles, 8);
                chk("t1_running", running, 1'b0);
            end
            halt_req = (c == 2);
            tick();
        end

        // Load with mem_done on the 5th M_WT cycle (wdog hits TIMEOUT alongside done).
        rst = 1'b1; tick(); rst = 1'b0;
        need_mem = 1'b1; need_wb = 1'b1; next_pc = 32'h84; dly[1] = 4;
        start = 1'b1; tick(); start = 1'b0;
        mem_cnt = 0; wb_c = 0; ret_c = 0; cyc15 = 0; pc15 = 0;
        for (int c = 1; c <= 16; c++) begin
            if (mem_en) mem_cnt++;
            if (wb_en) wb_c = c;
            if (retire && ret_c == 0) ret_c = c;
            if (c == 15) begin
                cyc15 = cycles;
                pc15  = pc;
            end
            halt_req = (c == 2);
            tick();
        end
        chk("t2_mem_pulses", mem_cnt, 1);
        chk("t2_wb_cycle", wb_c, 13);
        chk("t2_retire_cycle", ret_c, 15);
        chk("t2_cycles", cyc15, 14);
        chk("t2_pc", pc15, 32'h84);
        chk("t2_no_error", error, 1'b0);

        // Branch with rd=0: skips memory and writeback.
        need_mem = 1'b0; need_wb = 1'b0; next_pc = 32'h100; dly[1] = 0;
        start = 1'b1; tick(); start = 1'b0;
        mw_cnt = 0; ret_c = 0;
        for (int c = 1; c <= 8; c++) begin
            if (mem_en || wb_en) mw_cnt++;
            if (retire && ret_c == 0) ret_c = c;
            halt_req = (c == 2);
            tick();
        end
        chk("t3_no_mem_wb", mw_cnt, 0);
        chk("t3_retire_cycle", ret_c, 7);
        chk("t3_pc", pc, 32'h100);
        chk("t3_instret", instret, 2);

        // Halt pulsed in E_WT; resume fetches the new pc.
        need_wb = 1'b1; next_pc = 32'h104;
        start = 1'b1; tick(); start = 1'b0;
        chk("t4_fetch_pc", {fetch_en, pc}, {1'b1, 32'h100});
        for (int c = 1; c <= 8; c++) begin
            halt_req = (c == 6);
            tick();
        end
        chk("t4_retire", {retire, running}, 2'b10);
        f_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (fetch_en) f_cnt++;
            tick();
        end
        chk("t4_no_fetch", f_cnt, 0);
        chk("t4_pc", pc, 32'h104);
        chk("t4_instret", instret, 3);

        // Decode never completes: ERR after wdog reaches TIMEOUT in D_WT.
        dly[3] = 1000;
        start = 1'b1; tick(); start = 1'b0;
        chk("t5_fetch_pc", {fetch_en, pc}, {1'b1, 32'h104});
        for (int c = 1; c <= 7; c++) tick();
        chk("t5_pre_err", {error, running}, 2'b01);
        tick();
        chk("t5_err", {error, running}, 2'b10);
        chk("t5_err_en", en_vec, 5'b0);
        start = 1'b1; tick(); tick(); tick(); start = 1'b0;
        chk("t5_err_sticky", {error, fetch_en}, 2'b10);
        rst = 1'b1; tick(); rst = 1'b0;
        dly[3] = 0;
        chk("t5_rst_pc", pc, 32'h80);
        chk("t5_rst_err", error, 1'b0);

        // Reset mid-instruction in M_WT.
        need_mem = 1'b0; need_wb = 1'b1; next_pc = 32'h90;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            halt_req = (c == 2);
            tick();
        end
        chk("t6_pre_state", {pc, instret}, {32'h90, 32'd1});
        need_mem = 1'b1; dly[1] = 1000;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c <= 8; c++) tick();
        chk("t6_in_mwt", {running, error}, 2'b10);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_rst_pc", pc, 32'h80);
        chk("t6_rst_cnt", {instret, cycles}, 64'd0);
        chk("t6_rst_out", {en_vec, running, error, retire}, 8'd0);
        need_mem = 1'b0; dly[1] = 0;
        start = 1'b1; tick(); start = 1'b0;
        chk("t6_refetch", {fetch_en, pc}, {1'b1, 32'h80});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
